keycode_action_decoder: RTL
===========================

# keycode_action_decoder

Converts the 8-bit keyboard keycode from the NIOS-written keycode PIO into per-player movement and attack commands for the game logic. It filters transient codes, detects key presses, and latches commands once per video frame. Attacks are one-shot per press with a per-player cooldown. It sits between the keycode PIO `out_port` and the fighter state/sprite logic.

## Interface
- `STABLE_CYCLES`, 1024: consecutive clk cycles a keycode must hold before it is accepted. Legal range is 1..65535.
- `COOLDOWN_FRAMES`, 8: frames after an issued attack during which further attacks from the same player are discarded. Legal range is 0..15.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `keycode`  in  8  raw USB HID usage code. 0x00 means no key.
- `frame_tick`  in  1  one-cycle pulse per video frame, already in the clk domain.
- `accepted_code`  out  8  the current filtered keycode.
- `key_valid`  out  1  high when `accepted_code` is one of the ten mapped codes.
- `p1_move`, `p2_move`  out  2 each  movement level, encoded {right,left}.
- `p1_attack`, `p2_attack`  out  3 each  one-hot {kick,punch,jump}, held for one frame.

## Operation
- Key map:
  - P1: 0x04 = left, 0x07 = right, 0x1A = jump, 0x09 = punch, 0x0A = kick.
  - P2: 0x50 = left, 0x4F = right, 0x52 = jump, 0x0E = punch, 0x0F = kick.
  - Every other code is unmapped and produces no action.
- Stability filter (registers `cand`, 16-bit `cnt`):
  - If `keycode != cand`: `cand <= keycode`, `cnt <= 0`.
  - Otherwise, if `cnt < STABLE_CYCLES-1`: `cnt++`.
  - If `cnt == STABLE_CYCLES-1` and `cand != accepted_code`: `accepted_code <= cand`. This is an "accept" event. The counter saturates.
- Press detection:
  - On an accept whose new code is an attack code for player P: `pend_P <=` that one-hot. It overwrites any older pending attack.
  - An accept of 0x00, a movement code, or an unmapped code leaves `pend` unchanged. A tap released before the next frame is still delivered.
  - Holding a key never retriggers, because accept fires only when the code changes.
- Per-player FSM with states READY (`cool == 0`) and COOLDOWN (`cool != 0`). All updates happen on `frame_tick` only.
  - `pX_move <=` the move decode of `accepted_code` for that player. Both bits are never set at once.
  - READY with `pend != 0`: `pX_attack <= pend`, `pend <= 0`, `cool <= COOLDOWN_FRAMES`. The FSM enters COOLDOWN if `COOLDOWN_FRAMES > 0`.
  - READY with `pend == 0`: `pX_attack <= 0`.
  - COOLDOWN: `pX_attack <= 0`, `pend <= 0` (the attack is discarded, not buffered), `cool--`. The FSM returns to READY when `cool` reaches 0.
- Simultaneous accept and `frame_tick` in the same cycle:
  - The frame update uses the pre-edge `accepted_code` and `pend`.
  - A `pend` set by the new accept wins over the frame's clear, so the press is delivered next frame.
- Reset clears `cand`, `cnt`, `accepted_code`, `pend`, and `cool`. Every output is 0, and both FSMs are in READY.

## Timing
- A keycode change at edge k is sampled into `cand` at edge k+1. It is accepted at edge k+1+STABLE_CYCLES if it holds steadily (STABLE_CYCLES = 1 gives acceptance at k+2).
- `key_valid` is combinational from `accepted_code`.
- Move and attack outputs change only on the edge where `frame_tick` is high. They are stable for the whole following frame.
- Latency from an accepted press to its attack output is the next `frame_tick` edge (at most one frame).
- Reset assertion clears state immediately and asynchronously. Deassertion takes effect on a clk edge.
- After reset deassertion, a nonzero keycode needs the full filter time. No stale state survives.

## Test plan
- Glitch rejection (STABLE_CYCLES = 4):
  - `keycode` = 0x04 for 3 cycles, then 0x00 → `accepted_code` stays 0x00.
  - 0x04 held → `accepted_code` = 0x04 five edges after the change, `key_valid` = 1, next frame `p1_move` = 2'b01.
- One-shot attack: 0x09 held across 3 `frame_tick`s → `p1_attack` = 3'b010 for the first frame only, then 3'b000, and `p1_move` = 2'b00 throughout.
- Cooldown (COOLDOWN_FRAMES = 2):
  - Press 0x09, release, press 0x0A before the next frame → the 0x0A attack is discarded.
  - 0x0A repressed after 2 more frames → `p1_attack` = 3'b100.
- Quick tap plus P2 independence:
  - 0x52 accepted then 0x00 accepted before the next `frame_tick` → `p2_attack` = 3'b001, `p1_attack` = 0.
  - 0x50 held → `p2_move` = 2'b01.
- Same-cycle collision: an accept of 0x0E coincides with `frame_tick` → that frame gives `p2_attack` = 0, and the next frame gives 3'b010.
- Reset mid-cooldown with 0x04 held: assert `reset_n` = 0 → all outputs are 0 immediately. After deassertion, `accepted_code` = 0x04 only after STABLE_CYCLES+1 edges, and an attack fires at the first frame without waiting for the old cooldown.

Source files
------------

// File: rtl/keycode_action_decoder.sv
// keycode_action_decoder: filters PIO keycodes and latches per-player move/attack commands once per frame
module keycode_action_decoder #(
  parameter int STABLE_CYCLES   = 1024,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] keycode,
  input  logic       frame_tick,
  output logic [7:0] accepted_code,
  output logic       key_valid,
  output logic [1:0] p1_move,
  output logic [1:0] p2_move,
  output logic [2:0] p1_attack,
  output logic [2:0] p2_attack
);
  typedef enum logic {READY, COOLDOWN} state_t;
  localparam logic [15:0] LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [3:0]  CD   = 4'(COOLDOWN_FRAMES);

  logic [7:0]  cand;
  logic [15:0] cnt;
  logic        accept;
  state_t      state [2];
  state_t      state_n [2];
  logic [3:0]  cool [2];
  logic [3:0]  cool_n [2];
  logic [2:0]  pend [2];
  logic [2:0]  pend_n [2];
  logic [2:0]  atk [2];
  logic [2:0]  atk_n [2];
  logic [1:0]  mv [2];
  logic [1:0]  mv_n [2];

  function automatic logic [2:0] atk_dec(input logic [7:0] c, input logic p2);
    return p2 ? {c == 8'h0F, c == 8'h0E, c == 8'h52} : {c == 8'h0A, c == 8'h09, c == 8'h1A};
  endfunction

  function automatic logic [1:0] mv_dec(input logic [7:0] c, input logic p2);
    return p2 ? {c == 8'h4F, c == 8'h50} : {c == 8'h07, c == 8'h04};
  endfunction

  assign accept    = cnt == LAST && cand != accepted_code;
  assign key_valid = |{atk_dec(accepted_code, 1'b0), atk_dec(accepted_code, 1'b1),
                       mv_dec(accepted_code, 1'b0), mv_dec(accepted_code, 1'b1)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand          <= '0;
      cnt           <= '0;
      accepted_code <= '0;
    end else begin
      if (keycode != cand) begin
        cand <= keycode;
        cnt  <= '0;
      end else if (cnt < LAST) cnt <= cnt + 16'd1;
      if (accept) accepted_code <= cand;
    end
  end

  // A press accepted on a frame edge overrides that frame's pend clear, so it lands next frame
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      state_n[p] = state[p];
      cool_n[p]  = cool[p];
      pend_n[p]  = pend[p];
      atk_n[p]   = atk[p];
      mv_n[p]    = mv[p];
      if (frame_tick) begin
        mv_n[p]    = mv_dec(accepted_code, p == 1);
        atk_n[p]   = state[p] == READY ? pend[p] : 3'b000;
        pend_n[p]  = 3'b000;
        cool_n[p]  = state[p] == COOLDOWN ? cool[p] - 4'd1 : (pend[p] != 3'b000 ? CD : 4'd0);
        state_n[p] = state[p] == COOLDOWN ? (cool[p] != 4'd1 ? COOLDOWN : READY)
                                          : (pend[p] != 3'b000 && CD != 4'd0 ? COOLDOWN : READY);
      end
      if (accept && atk_dec(cand, p == 1) != 3'b000) pend_n[p] = atk_dec(cand, p == 1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < 2; p++) begin
        state[p] <= READY;
        cool[p]  <= '0;
        pend[p]  <= '0;
        atk[p]   <= '0;
        mv[p]    <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        state[p] <= state_n[p];
        cool[p]  <= cool_n[p];
        pend[p]  <= pend_n[p];
        atk[p]   <= atk_n[p];
        mv[p]    <= mv_n[p];
      end
    end
  end

  assign p1_move   = mv[0];
  assign p2_move   = mv[1];
  assign p1_attack = atk[0];
  assign p2_attack = atk[1];
endmodule
